backtrack_stack: RTL and testbench
==================================

BACKTRACK_STACK -- requirements
Module: backtrack_stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of stack entries; power of two, minimum 2.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clear  input  1  synchronous flush strobe; pulsed by the sequencer in its load-init state.
REQ-006 push  input  1  push strobe; push_data is written this cycle.
REQ-007 push_data  input  WIDTH  word to push.
REQ-008 pop  input  1  pop strobe; removes the top entry.
REQ-009 fail_in  input  1  candidate-rejected flag from the ALU; sampled combinationally into backtrack.
REQ-010 top_data  output  WIDTH  registered copy of the current top entry; 0 when empty.
REQ-011 count  output  clog2(DEPTH)+1  number of valid entries.
REQ-012 empty  output  1  count == 0.
REQ-013 full  output  1  count == DEPTH.
REQ-014 backtrack  output  1  sequencer must unwind: fail_in OR full, while in RUN.
REQ-015 done  output  1  unwind complete: state == UNWIND AND empty.
REQ-016 err  output  1  sticky overflow/underflow flag.

Function
REQ-017 Internal FSM states SHALL be IDLE, RUN, UNWIND and ERR.
REQ-018 clear SHALL have top priority in every state: count <= 0, top_data <= 0, err <= 0, next state IDLE.
REQ-019 IDLE: push (not full) SHALL write the entry, count +1, and move to RUN; pop SHALL set err and move to ERR.
REQ-020 RUN: push alone with count < DEPTH SHALL write mem[count], count +1, top_data <= push_data.
REQ-021 RUN: push alone with full SHALL not write, SHALL set err and move to ERR.
REQ-022 RUN: pop alone with count > 0 SHALL decrement count, update top_data to the new top (0 if new count is 0), and move to UNWIND.
REQ-023 RUN: push and pop in the same cycle SHALL overwrite the top entry with push_data, leave count unchanged, and stay in RUN; on an empty stack this is a plain push.
REQ-024 UNWIND: push SHALL be ignored (no write, no error); pop with count > 0 SHALL decrement as in REQ-022; pop while empty SHALL set err and move to ERR.
REQ-025 UNWIND SHALL be held until clear, so done stays high once the stack drains.
REQ-026 ERR: push and pop SHALL be ignored, contents frozen, err held 1 until clear.
REQ-027 top_data SHALL reflect any push/pop one clock after the strobe edge (one-cycle latency); count, empty, full likewise registered-derived.
REQ-028 backtrack and done SHALL be combinational from state, count and fail_in; no added latency.
REQ-029 Memory contents above count are don't-care and SHALL never appear on top_data.

Reset
REQ-030 rst SHALL force state IDLE, count 0, top_data 0, err 0, empty 1, full 0, done 0, backtrack 0, independent of clk.
REQ-031 rst asserted mid-operation SHALL discard all entries; first push after release lands at index 0.
REQ-032 Memory array needs no reset.

Verification
REQ-033 Reset, push 0x11,0x22,0x33 -> count 3, top_data 0x33 one cycle after last push, empty 0, done 0.
REQ-034 From REQ-033 state pop three times -> top_data 0x22,0x11,0x00; after third pop empty 1, done 1; further push ignored, count stays 0.
REQ-035 DEPTH=8: eight pushes -> full 1, backtrack 1; ninth push -> err 1, count 8, top_data unchanged; clear -> err 0, count 0, IDLE.
REQ-036 RUN with 0x44 on top, push 0x55 and pop same cycle -> count unchanged, top_data 0x55, still RUN; fail_in=1 -> backtrack 1 same cycle.
REQ-037 pop on empty after reset -> err 1; push while err -> ignored; rst asserted between clk edges -> all outputs at reset values immediately.

Source files
------------

// File: rtl/backtrack_stack.sv
// Backtrack stack: LIFO of candidate words for a search sequencer.
// Pushes extend the current path, pops unwind it, and an FSM tracks whether
// the sequencer is building (RUN), unwinding (UNWIND) or in an error state.
module backtrack_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       fail_in,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       backtrack,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    UNWIND = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             err_q, err_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             full_c;
  logic             empty_c;
  logic [WIDTH-1:0] pop_top_c;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  // Entry that becomes the top after a pop; zero when the pop empties the stack.
  always_comb begin
    pop_top_c = '0;
    if (count_q >= CW'(2)) begin
      pop_top_c = mem[AW'(count_q - CW'(2))];
    end
  end

  // Next-state, next-count, next-top and memory write decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    top_d     = top_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = push_data;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      top_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // push together with pop on an empty stack degrades to a plain push
          if (push && !full_c) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(count_q);
            count_d   = count_q + CW'(1);
            top_d     = push_data;
            state_d   = RUN;
          end else if (pop) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end

        RUN: begin
          if (push && pop) begin
            if (empty_c) begin
              mem_we    = 1'b1;
              mem_waddr = AW'(count_q);
              count_d   = count_q + CW'(1);
              top_d     = push_data;
            end else begin
              // replace the current top in place
              mem_we    = 1'b1;
              mem_waddr = AW'(count_q - CW'(1));
              top_d     = push_data;
            end
          end else if (push) begin
            if (full_c) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = AW'(count_q);
              count_d   = count_q + CW'(1);
              top_d     = push_data;
            end
          end else if (pop) begin
            if (!empty_c) begin
              count_d = count_q - CW'(1);
              top_d   = pop_top_c;
              state_d = UNWIND;
            end else begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          end
        end

        UNWIND: begin
          // pushes are dropped while unwinding; only pops make progress
          if (pop) begin
            if (!empty_c) begin
              count_d = count_q - CW'(1);
              top_d   = pop_top_c;
            end else begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          end
        end

        ERR: begin
          err_d = 1'b1;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      top_q   <= top_d;
      err_q   <= err_d;
    end
  end

  // Stack storage; entries above count are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign top_data  = top_q;
  assign count     = count_q;
  assign empty     = empty_c;
  assign full      = full_c;
  assign err       = err_q;
  assign backtrack = (state_q == RUN) && (fail_in || full_c);
  assign done      = (state_q == UNWIND) && empty_c;

endmodule

// File: tb/tb_backtrack_stack.sv
// Directed bench for backtrack_stack (WIDTH=8, DEPTH=8): a vector table of
// single-cycle operations with hand-computed results, then short sequences
// for same-cycle backtrack, asynchronous reset and the held done state.
module tb_backtrack_stack;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic       fail_in;
  logic [7:0] top_data;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       backtrack;
  logic       done;
  logic       err;

  int n_tests;
  int n_fail;

  // flags = {empty, full, err, backtrack, done}
  typedef struct {
    logic       clr;
    logic       psh;
    logic       pp;
    logic       fl;
    logic [7:0] d;
    logic [3:0] cnt;
    logic [7:0] top;
    logic [4:0] flags;
  } vec_t;

  vec_t vecs[$];

  backtrack_stack #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .fail_in   (fail_in),
    .top_data  (top_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .backtrack (backtrack),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic c, input logic pu, input logic po, input logic f,
                     input logic [7:0] d, input logic [3:0] cnt, input logic [7:0] top,
                     input logic [4:0] flags);
    vec_t v;
    v.clr = c; v.psh = pu; v.pp = po; v.fl = f; v.d = d;
    v.cnt = cnt; v.top = top; v.flags = flags;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] cnt, input logic [7:0] top,
                       input logic [4:0] flags);
    logic [16:0] got;
    logic [16:0] exp;
    got = {count, top_data, empty, full, err, backtrack, done};
    exp = {cnt, top, flags};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d top=%h eflags=%b, want cnt=%0d top=%h eflags=%b",
               name, got[16:13], got[12:5], got[4:0], exp[16:13], exp[12:5], exp[4:0]);
    end
  endtask

  task automatic drive(input logic c, input logic pu, input logic po, input logic f,
                       input logic [7:0] d);
    @(negedge clk);
    clear = c; push = pu; pop = po; fail_in = f; push_data = d;
  endtask

  task automatic step(input logic c, input logic pu, input logic po, input logic f,
                      input logic [7:0] d);
    drive(c, pu, po, f, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; fail_in = 1'b0; push_data = '0;

    // build the vector table
    add(0,1,0,0,8'h11, 1,8'h11,5'b00000);
    add(0,1,0,0,8'h22, 2,8'h22,5'b00000);
    add(0,1,0,0,8'h33, 3,8'h33,5'b00000);
    add(0,0,1,0,8'h00, 2,8'h22,5'b00000);
    add(0,0,1,0,8'h00, 1,8'h11,5'b00000);
    add(0,0,1,0,8'h00, 0,8'h00,5'b10001);
    add(0,1,0,0,8'h99, 0,8'h00,5'b10001);
    add(1,0,0,0,8'h00, 0,8'h00,5'b10000);
    for (int i = 1; i <= 8; i++) begin
      add(0,1,0,0,8'(i), 4'(i), 8'(i), (i == 8) ? 5'b01010 : 5'b00000);
    end
    add(0,1,0,0,8'hAA, 8,8'h08,5'b01100);
    add(0,0,1,0,8'h00, 8,8'h08,5'b01100);
    add(1,0,0,0,8'h00, 0,8'h00,5'b10000);
    add(0,1,0,0,8'h44, 1,8'h44,5'b00000);
    add(0,1,1,0,8'h55, 1,8'h55,5'b00000);
    add(0,0,0,1,8'h00, 1,8'h55,5'b00010);
    add(0,0,0,0,8'h00, 1,8'h55,5'b00000);
    add(0,0,1,0,8'h00, 0,8'h00,5'b10001);
    add(1,0,0,0,8'h00, 0,8'h00,5'b10000);
    add(0,1,0,0,8'h10, 1,8'h10,5'b00000);
    add(0,1,0,0,8'h20, 2,8'h20,5'b00000);
    add(0,1,1,0,8'h30, 2,8'h30,5'b00000);
    add(0,0,1,0,8'h00, 1,8'h10,5'b00000);
    add(0,0,1,0,8'h00, 0,8'h00,5'b10001);
    add(0,0,1,0,8'h00, 0,8'h00,5'b10100);
    add(1,0,0,0,8'h00, 0,8'h00,5'b10000);
    add(0,0,1,0,8'h00, 0,8'h00,5'b10100);
    add(0,1,0,0,8'h77, 0,8'h00,5'b10100);
    add(1,0,0,0,8'h00, 0,8'h00,5'b10000);
    add(0,1,1,0,8'h66, 1,8'h66,5'b00000);
    add(1,1,0,0,8'h12, 0,8'h00,5'b10000);
    add(0,1,0,0,8'h21, 1,8'h21,5'b00000);

    // reset state
    #12;
    check("reset_hold", 0, 8'h00, 5'b10000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 0, 8'h00, 5'b10000);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].psh, vecs[i].pp, vecs[i].fl, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].top, vecs[i].flags);
    end

    // backtrack follows fail_in within the same cycle (RUN, count 1, top 0x21)
    drive(0,0,0,1,8'h00);
    #1;
    check("bt_comb_rise", 1, 8'h21, 5'b00010);
    fail_in = 1'b0;
    #1;
    check("bt_comb_fall", 1, 8'h21, 5'b00000);

    // asynchronous reset between clock edges discards everything
    step(0,1,0,0,8'h31);
    check("pre_rst_push", 2, 8'h31, 5'b00000);
    drive(0,0,0,0,8'h00);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 0, 8'h00, 5'b10000);
    @(negedge clk);
    rst = 1'b0;
    step(0,1,0,0,8'hA1);
    check("post_rst_push0", 1, 8'hA1, 5'b00000);
    step(0,1,0,0,8'hB2);
    check("post_rst_push1", 2, 8'hB2, 5'b00000);
    step(0,0,1,0,8'h00);
    check("post_rst_pop_idx0", 1, 8'hA1, 5'b00000);

    // done stays high while UNWIND holds an empty stack
    step(0,0,1,0,8'h00);
    check("drain", 0, 8'h00, 5'b10001);
    for (int k = 0; k < 3; k++) begin
      step(0,1,0,1,8'hC3);
      check($sformatf("done_hold%0d", k), 0, 8'h00, 5'b10001);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
